io_input_conditioner: RTL and testbench
=======================================

IO_INPUT_CONDITIONER -- requirements
Module: io_input_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, giving the number of consecutive stable cycles required to accept a new level (20 ms at 50 MHz).
REQ-002 The block SHALL have parameter SW_WIDTH, default 9, giving the number of slide-switch inputs.
REQ-003 The block SHALL have parameter BTN_WIDTH, default 4, giving the number of push-button inputs.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock, active on the rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-006 The block SHALL have port sw_i, input, SW_WIDTH bits: raw asynchronous switch levels.
REQ-007 The block SHALL have port key_i, input, BTN_WIDTH bits: raw asynchronous buttons, active-low (0 = pressed).
REQ-008 The block SHALL have port io_sw_o, output, 32 bits: {zeros, debounced sw}, which feeds the core's io_sw_i.
REQ-009 The block SHALL have port io_btn_o, output, BTN_WIDTH bits: debounced button level, active-low, which feeds the core's io_btn_i.
REQ-010 The block SHALL have port btn_press_o, output, BTN_WIDTH bits: a one-cycle pulse on each debounced 1->0 transition.
REQ-011 The block SHALL have port btn_release_o, output, BTN_WIDTH bits: a one-cycle pulse on each debounced 0->1 transition.
REQ-012 The block SHALL have port sw_change_o, output, SW_WIDTH bits: a one-cycle pulse on any debounced switch transition.

Function
REQ-013 Each input bit SHALL pass through a 2-flop synchronizer (s1, then s2) before any other logic uses it.
REQ-014 Each input bit SHALL have an independent debounced state D and a counter C of width $clog2(DEBOUNCE_CYCLES)+1.
REQ-015 On each edge, if s2 == D, the block SHALL set C <= 0.
REQ-016 On each edge, if s2 != D and C == DEBOUNCE_CYCLES-1, the block SHALL set D <= s2 and C <= 0.
REQ-017 On each edge, if s2 != D and C < DEBOUNCE_CYCLES-1, the block SHALL set C <= C+1.
REQ-018 Latency: if a pin changes before edge k and then holds, D SHALL change at edge k+1+DEBOUNCE_CYCLES; for example, with DEBOUNCE_CYCLES=4 and the change before edge 1, D changes at edge 6.
REQ-019 Any return of s2 to D before acceptance (a bounce) SHALL clear C, so the full DEBOUNCE_CYCLES count restarts.
REQ-020 Pulse outputs SHALL be registered, and SHALL be high exactly in the cycle following the edge at which D changed, for one cycle only.
REQ-021 Pulses from different bits SHALL be independent; simultaneous transitions on several bits SHALL assert all corresponding pulses in the same cycle.
REQ-022 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-023 DEBOUNCE_CYCLES SHALL be at least 1; with a value of 1, D changes at edge k+2.
REQ-024 io_sw_o[31:SW_WIDTH] SHALL be constant 0.

Reset
REQ-025 While rst_i is high at an edge, the block SHALL set all switch s1, s2 and D to 0, and all button s1, s2 and D to 1 (released).
REQ-026 While rst_i is high at an edge, the block SHALL set all counters to 0 and all pulse outputs to 0.
REQ-027 Reset output values SHALL be: io_sw_o = 0, io_btn_o = all 1, btn_press_o = 0, btn_release_o = 0, sw_change_o = 0.
REQ-028 A reset asserted mid-count SHALL discard the partial count.
REQ-029 A reset SHALL NOT generate any pulse, either on entry or on exit.
REQ-030 After rst_i deasserts, a pin level that differs from the reset value SHALL be accepted as a normal transition and SHALL pulse.

Structure
REQ-031 Package io_input_pkg SHALL hold the default DEBOUNCE_CYCLES, SW_WIDTH, BTN_WIDTH, CORE_IO_WIDTH = 32, and the reset levels for switches (0) and buttons (1).
REQ-032 Sub-module debounce_cell SHALL contain one bit's synchronizer, counter, state D and rise/fall pulse logic, with a parameter for the reset level.
REQ-033 The top level SHALL instantiate debounce_cell SW_WIDTH+BTN_WIDTH times via generate loops.
REQ-034 The top level SHALL contain only instantiation, zero-extension and output mapping, with no further logic.

Verification (DEBOUNCE_CYCLES = 4)
REQ-035 Scenario, reset: hold rst_i high for 2 cycles with key_i = 4'hF and sw_i = 0 -> io_btn_o = 4'hF, io_sw_o = 0, all pulses 0.
REQ-036 Scenario, clean press: key_i[0] goes 1->0 before edge 1 and holds -> io_btn_o[0] = 0 after edge 6, btn_press_o[0] high for exactly 1 cycle after edge 6.
REQ-037 Scenario, bounce: key_i[1] toggles 0,1,0,1 on successive cycles, then holds 0 -> no change until 4 stable cycles have passed through s2, and exactly one press pulse.
REQ-038 Scenario, switch: sw_i = 9'h1A5 held -> io_sw_o = 32'h000001A5 after 6 edges; sw_change_o = 9'h1A5 for one cycle.
REQ-039 Scenario, simultaneous events: release key 2 and key 3 together -> btn_release_o = 4'b1100 in the same single cycle.
REQ-040 Scenario, reset mid-count: assert rst_i when C = 2 -> after reset, the count restarts from 0 with no pulse during reset, and the accepted transition pulses once afterwards.

Source files
------------

// File: rtl/io_input_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_input_pkg
// Description : Shared constants for the board input conditioner. Holds the
//               default debounce length, the switch and button widths, the
//               core IO bus width, the reset (idle) level of each input class,
//               and a helper that sizes the debounce counter.
// Revision    : 1.0 - initial release
// ============================================================================
package io_input_pkg;

  localparam int   DEFAULT_DEBOUNCE_CYCLES = 1_000_000;  // 20 ms at 50 MHz
  localparam int   DEFAULT_SW_WIDTH        = 9;
  localparam int   DEFAULT_BTN_WIDTH       = 4;
  localparam int   CORE_IO_WIDTH           = 32;

  // Idle levels: switches read low, buttons are active-low and read released.
  localparam logic SW_RESET_LEVEL          = 1'b0;
  localparam logic BTN_RESET_LEVEL         = 1'b1;

  // Counter width. The extra bit keeps the width at least 1 when cycles == 1.
  function automatic int debounce_cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage : io_input_pkg
`default_nettype wire

// File: rtl/debounce_cell.sv
`default_nettype none
// ============================================================================
// Module      : debounce_cell
// Description : One input bit. The cell has a 2-flop synchronizer, a
//               stable-level counter, the accepted (debounced) level, and
//               registered one-cycle rise/fall/change pulses.
// Ports       : clk      - rising-edge clock
//               rst      - synchronous active-high reset
//               i_raw    - raw asynchronous pin level
//               o_level  - debounced level
//               o_rise   - one-cycle pulse after an accepted 0->1
//               o_fall   - one-cycle pulse after an accepted 1->0
//               o_change - one-cycle pulse after any accepted transition
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_cell
  import io_input_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_change
);

  localparam int               CNT_W      = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rise;
  logic             r_fall;
  logic             r_change;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1     <= RESET_LEVEL;
      r_s2     <= RESET_LEVEL;
      r_level  <= RESET_LEVEL;
      r_cnt    <= '0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_change <= 1'b0;
    end else begin
      r_s1     <= i_raw;
      r_s2     <= r_s1;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_change <= 1'b0;
      if (r_s2 == r_level) begin
        // Agreement, or a bounce back: any partial count is discarded.
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_LAST) begin
        // The new level has been stable long enough, so accept it. The pulses
        // appear together with the new level.
        r_level  <= r_s2;
        r_cnt    <= '0;
        r_rise   <= r_s2;
        r_fall   <= ~r_s2;
        r_change <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level  = r_level;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;
  assign o_change = r_change;

endmodule : debounce_cell
`default_nettype wire

// File: rtl/io_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : io_input_conditioner
// Description : Synchronizes and debounces the board slide switches and
//               push-buttons for the core. It also produces one-cycle event
//               pulses.
// Ports       : clk_i         - rising-edge clock
//               rst_i         - synchronous active-high reset
//               sw_i          - raw switch levels
//               key_i         - raw buttons, active-low (0 = pressed)
//               io_sw_o       - zero-extended debounced switches
//               io_btn_o      - debounced buttons, active-low
//               btn_press_o   - pulse on a debounced 1->0 button transition
//               btn_release_o - pulse on a debounced 0->1 button transition
//               sw_change_o   - pulse on any debounced switch transition
// Revision    : 1.0 - initial release
// ============================================================================
module io_input_conditioner
  import io_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SW_WIDTH        = DEFAULT_SW_WIDTH,
  parameter int BTN_WIDTH       = DEFAULT_BTN_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [SW_WIDTH-1:0]      sw_i,
  input  logic [BTN_WIDTH-1:0]     key_i,
  output logic [CORE_IO_WIDTH-1:0] io_sw_o,
  output logic [BTN_WIDTH-1:0]     io_btn_o,
  output logic [BTN_WIDTH-1:0]     btn_press_o,
  output logic [BTN_WIDTH-1:0]     btn_release_o,
  output logic [SW_WIDTH-1:0]      sw_change_o
);

  logic [SW_WIDTH-1:0]  w_sw_level;
  logic [SW_WIDTH-1:0]  w_sw_rise_unused;
  logic [SW_WIDTH-1:0]  w_sw_fall_unused;
  logic [BTN_WIDTH-1:0] w_btn_change_unused;

  for (genvar g = 0; g < SW_WIDTH; g++) begin : g_sw
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (SW_RESET_LEVEL)
    ) u_cell (
      .clk      (clk_i),
      .rst      (rst_i),
      .i_raw    (sw_i[g]),
      .o_level  (w_sw_level[g]),
      .o_rise   (w_sw_rise_unused[g]),
      .o_fall   (w_sw_fall_unused[g]),
      .o_change (sw_change_o[g])
    );
  end

  // The buttons are active-low, so a press is a falling level.
  for (genvar g = 0; g < BTN_WIDTH; g++) begin : g_btn
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (BTN_RESET_LEVEL)
    ) u_cell (
      .clk      (clk_i),
      .rst      (rst_i),
      .i_raw    (key_i[g]),
      .o_level  (io_btn_o[g]),
      .o_rise   (btn_release_o[g]),
      .o_fall   (btn_press_o[g]),
      .o_change (w_btn_change_unused[g])
    );
  end

  assign io_sw_o = CORE_IO_WIDTH'(w_sw_level);

endmodule : io_input_conditioner
`default_nettype wire

// File: tb/tb_io_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_input_conditioner
// Description : Self-checking bench for io_input_conditioner, DEBOUNCE_CYCLES=4.
//               The reference model treats each bit as a sliding window of
//               pin samples. A bit's level flips when the N samples that have
//               crossed the synchronizer all disagree with it. Reset flushes
//               the window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_input_conditioner;
  import io_input_pkg::*;

  localparam int N     = 4;
  localparam int SW_W  = 9;
  localparam int BTN_W = 4;
  localparam int NB    = SW_W + BTN_W;  // bits 0..8 switches, 9..12 buttons

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [SW_W-1:0]  sw_i;
  logic [BTN_W-1:0] key_i;
  logic [31:0]      io_sw_o;
  logic [BTN_W-1:0] io_btn_o;
  logic [BTN_W-1:0] btn_press_o;
  logic [BTN_W-1:0] btn_release_o;
  logic [SW_W-1:0]  sw_change_o;

  always #5 clk_i = ~clk_i;

  io_input_conditioner #(
    .DEBOUNCE_CYCLES (N),
    .SW_WIDTH        (SW_W),
    .BTN_WIDTH       (BTN_W)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .sw_i          (sw_i),
    .key_i         (key_i),
    .io_sw_o       (io_sw_o),
    .io_btn_o      (io_btn_o),
    .btn_press_o   (btn_press_o),
    .btn_release_o (btn_release_o),
    .sw_change_o   (sw_change_o)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int edge_n = 0;

  // m_hist[b][j] holds the pin sample taken j+1 edges ago.
  logic [N:0] m_hist [NB];
  logic       m_lvl  [NB];
  logic       m_rise [NB];
  logic       m_fall [NB];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, edge_n);
  endtask

  function automatic logic idle_level(input int b);
    return (b >= SW_W) ? BTN_RESET_LEVEL : SW_RESET_LEVEL;
  endfunction

  task automatic model_edge();
    logic x;
    for (int b = 0; b < NB; b++) begin
      x = (b < SW_W) ? sw_i[b] : key_i[b-SW_W];
      m_rise[b] = 1'b0;
      m_fall[b] = 1'b0;
      if (rst_i) begin
        m_lvl[b]  = idle_level(b);
        m_hist[b] = {(N+1){idle_level(b)}};
      end else begin
        // The samples from 2..N+1 edges ago have reached the decision point.
        if (m_hist[b][N:1] == {N{~m_lvl[b]}}) begin
          m_lvl[b]  = ~m_lvl[b];
          m_rise[b] = m_lvl[b];
          m_fall[b] = ~m_lvl[b];
        end
        m_hist[b] = {m_hist[b][N-1:0], x};
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] e_sw, e_chg, e_btn, e_prs, e_rel;
    e_sw = '0; e_chg = '0; e_btn = '0; e_prs = '0; e_rel = '0;
    for (int b = 0; b < SW_W; b++) begin
      e_sw[b]  = m_lvl[b];
      e_chg[b] = m_rise[b] | m_fall[b];
    end
    for (int k = 0; k < BTN_W; k++) begin
      e_btn[k] = m_lvl[SW_W+k];
      e_prs[k] = m_fall[SW_W+k];
      e_rel[k] = m_rise[SW_W+k];
    end
    check("io_sw",       io_sw_o,               e_sw);
    check("sw_change",   32'(sw_change_o),      e_chg);
    check("io_btn",      32'(io_btn_o),         e_btn);
    check("btn_press",   32'(btn_press_o),      e_prs);
    check("btn_release", 32'(btn_release_o),    e_rel);
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    edge_n++;
    #1;
    compare_all();
  endtask

  initial begin
    int press_edge;
    int press_cnt;
    int rel_hits;

    for (int b = 0; b < NB; b++) begin
      m_hist[b] = {(N+1){idle_level(b)}};
      m_lvl[b]  = idle_level(b);
      m_rise[b] = 1'b0;
      m_fall[b] = 1'b0;
    end

    // Reset scenario.
    rst_i = 1'b1; key_i = 4'hF; sw_i = '0;
    tick(); tick();
    check("rst_btn",   32'(io_btn_o),    32'h0000000F);
    check("rst_sw",    io_sw_o,          32'h0);
    check("rst_press", 32'(btn_press_o), 32'h0);

    // Clean press on key 0. The change is driven before edge 1.
    rst_i = 1'b0; key_i = 4'hE; edge_n = 0; press_edge = -1; press_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (btn_press_o[0]) begin press_cnt++; press_edge = edge_n; end
    end
    check("press_edge", 32'(press_edge), 32'd6);
    check("press_once", 32'(press_cnt),  32'd1);
    key_i = 4'hF;
    for (int i = 0; i < 8; i++) tick();

    // Bouncing key 1.
    press_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      key_i[1] = i[0];
      tick();
      if (btn_press_o[1]) press_cnt++;
    end
    key_i[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (btn_press_o[1]) press_cnt++;
    end
    check("bounce_once", 32'(press_cnt), 32'd1);
    key_i = 4'hF;
    for (int i = 0; i < 8; i++) tick();

    // Switch pattern.
    sw_i = 9'h1A5;
    for (int i = 0; i < 8; i++) tick();
    check("sw_value", io_sw_o, 32'h000001A5);

    // Keys 2 and 3 are pressed, then released together.
    key_i = 4'b0011;
    for (int i = 0; i < 8; i++) tick();
    key_i = 4'hF; rel_hits = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (btn_release_o == 4'b1100) rel_hits++;
    end
    check("simul_release", 32'(rel_hits), 32'd1);

    // Reset mid-count. After edge 4 the key-0 counter holds 2.
    key_i = 4'hE; press_cnt = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (btn_press_o[0]) press_cnt++; end
    rst_i = 1'b1;
    tick(); if (btn_press_o[0]) press_cnt++;
    rst_i = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); if (btn_press_o[0]) press_cnt++; end
    check("rst_midcount_once", 32'(press_cnt), 32'd1);

    // Randomized stretch: sparse toggles allow acceptances, and rare resets occur.
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < SW_W; b++)  if ($urandom_range(7) == 0) sw_i[b]  = ~sw_i[b];
      for (int b = 0; b < BTN_W; b++) if ($urandom_range(7) == 0) key_i[b] = ~key_i[b];
      rst_i = ($urandom_range(199) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_io_input_conditioner
`default_nettype wire
